// File: rtl/dcache_wt_if.sv
// Core-side and memory-side signals of the write-through data cache, bundled for port connection.
// The slave modport is the cache's view; the master modport is the core/memory side.
interface dcache_wt_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wrdata;
    logic [31:0] cpu_rddata;
    logic        cpu_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wrdata, mem_rddata, mem_ready,
        output cpu_rddata, cpu_stall, mem_read, mem_write, mem_addr, mem_wrdata,
               hit_count, miss_count
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wrdata, mem_rddata, mem_ready,
        input  cpu_rddata, cpu_stall, mem_read, mem_write, mem_addr, mem_wrdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Aligned load hits return data combinationally; everything else goes to memory.
//
// state   | meaning
// IDLE    | accepting requests; load hits served with no stall
// RD_WAIT | load miss or bypass outstanding, mem_read held
// WR_WAIT | store outstanding, mem_write held
// RESP    | one unstalled cycle presenting resp_data, then back to IDLE
module dcache_wt #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rstn,
    dcache_wt_if.slave  bus
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_ram  [LINES];
    logic [31:0]         data_ram [LINES];

    logic [31:0] resp_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  aligned;
    logic                  hit;

    logic        stall;
    logic [31:0] rddata;
    logic        issue_rd;
    logic        issue_wr;
    logic        ld_hit;
    logic        mem_done;
    logic        rd_done;
    logic        fill;

    assign idx     = bus.cpu_addr[INDEX_BITS+1:2];
    assign tag     = bus.cpu_addr[31:INDEX_BITS+2];
    assign aligned = (bus.cpu_addr[1:0] == 2'b00);
    assign hit     = valid[idx] && (tag_ram[idx] == tag) && aligned;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        rddata    = resp_data;
        issue_rd  = 1'b0;
        issue_wr  = 1'b0;
        ld_hit    = 1'b0;
        mem_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_write) begin
                    stall     = 1'b1;
                    issue_wr  = 1'b1;
                    state_nxt = WR_WAIT;
                end else if (bus.cpu_read && hit) begin
                    rddata = data_ram[idx];
                    ld_hit = 1'b1;
                end else if (bus.cpu_read) begin
                    stall     = 1'b1;
                    issue_rd  = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    mem_done  = 1'b1;
                    state_nxt = RESP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rd_done = mem_done && (state == RD_WAIT);
    // Unaligned loads were serviced by memory's lane alignment; never cache them.
    assign fill    = rd_done && aligned;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            valid      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wrdata <= '0;
            resp_data  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (issue_wr) begin
                mem_write  <= 1'b1;
                mem_addr   <= bus.cpu_addr;
                mem_wrdata <= bus.cpu_wrdata;
            end else if (issue_rd) begin
                mem_read <= 1'b1;
                mem_addr <= bus.cpu_addr;
            end
            if (mem_done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (rd_done) begin
                resp_data <= bus.mem_rddata;
            end
            if (fill) begin
                valid[idx] <= 1'b1;
            end
            if (ld_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (issue_rd && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Tag/data arrays need no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (issue_wr && hit) begin
                data_ram[idx] <= bus.cpu_wrdata;
            end
            if (fill) begin
                tag_ram[idx]  <= tag;
                data_ram[idx] <= bus.mem_rddata;
            end
        end
    end

    assign bus.cpu_stall  = stall;
    assign bus.cpu_rddata = rddata;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wrdata = mem_wrdata;
    assign bus.hit_count  = hit_count;
    assign bus.miss_count = miss_count;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: hit/miss latency, write-through, no-allocate,
// conflicts, unaligned bypass and reset during an outstanding read.
module tb_dcache_wt;
    logic clk;
    logic rstn;

    dcache_wt_if bus ();

    dcache_wt #(.INDEX_BITS(6)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          r_stalls;
    logic [31:0] r_data;
    logic        r_saw_rd;
    logic        r_saw_wr;
    logic        r_both;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request at posedge+1 and act as memory with the given latency.
    // Returns at posedge+1 after the cycle in which the core saw stall low.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mdata, input int lat);
        int  mem_cyc;
        bit  done;
        mem_cyc  = 0;
        done     = 0;
        r_stalls = 0;
        r_data   = '0;
        r_saw_rd = 0;
        r_saw_wr = 0;
        r_both   = 0;
        r_addr   = '0;
        r_wdata  = '0;
        bus.cpu_write  = wr;
        bus.cpu_read   = !wr;
        bus.cpu_addr   = addr;
        bus.cpu_wrdata = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_read && bus.mem_write) r_both = 1;
            if (bus.mem_read || bus.mem_write) begin
                r_saw_rd = r_saw_rd | bus.mem_read;
                r_saw_wr = r_saw_wr | bus.mem_write;
                r_addr   = bus.mem_addr;
                r_wdata  = bus.mem_wrdata;
                mem_cyc++;
                if (mem_cyc == lat) begin
                    bus.mem_ready  = 1'b1;
                    bus.mem_rddata = mdata;
                end
            end
            if (!bus.cpu_stall) begin
                r_data = bus.cpu_rddata;
                done   = 1;
            end else begin
                r_stalls++;
            end
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    initial begin
        rstn           = 1'b0;
        bus.cpu_read   = 1'b0;
        bus.cpu_write  = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wrdata = '0;
        bus.mem_rddata = '0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        check("rst_stall",   {31'd0, bus.cpu_stall}, 32'd0);
        check("rst_rddata",  bus.cpu_rddata,         32'd0);
        check("rst_mem_rd",  {31'd0, bus.mem_read},  32'd0);
        check("rst_mem_wr",  {31'd0, bus.mem_write}, 32'd0);
        check("rst_mem_adr", bus.mem_addr,           32'd0);
        check("rst_hits",    bus.hit_count,          32'd0);
        check("rst_misses",  bus.miss_count,         32'd0);

        // Cold load, memory answers in its 3rd cycle.
        access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
        check("cold_stalls", r_stalls,         32'd4);
        check("cold_data",   r_data,           32'hDEADBEEF);
        check("cold_memrd",  {31'd0, r_saw_rd}, 32'd1);
        check("cold_addr",   r_addr,           32'h10);
        check("cold_miss",   bus.miss_count,   32'd1);
        check("cold_hit",    bus.hit_count,    32'd0);

        access(1'b0, 32'h10, 32'h0, 32'h0, 1);
        check("hit_stalls",  r_stalls,          32'd0);
        check("hit_data",    r_data,            32'hDEADBEEF);
        check("hit_memrd",   {31'd0, r_saw_rd}, 32'd0);
        check("hit_count",   bus.hit_count,     32'd1);

        // Store to a cached line: written through and updated locally.
        access(1'b1, 32'h10, 32'h12345678, 32'h0, 2);
        check("st_stalls",   r_stalls,          32'd3);
        check("st_memwr",    {31'd0, r_saw_wr}, 32'd1);
        check("st_memrd",    {31'd0, r_saw_rd}, 32'd0);
        check("st_addr",     r_addr,            32'h10);
        check("st_wdata",    r_wdata,           32'h12345678);
        check("st_miss",     bus.miss_count,    32'd1);

        access(1'b0, 32'h10, 32'h0, 32'h0, 1);
        check("sthit_data",  r_data,            32'h12345678);
        check("sthit_memrd", {31'd0, r_saw_rd}, 32'd0);
        check("sthit_count", bus.hit_count,     32'd2);

        // Store to an uncached line does not allocate.
        access(1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1);
        check("nwa_stalls",  r_stalls,          32'd2);
        check("nwa_wdata",   r_wdata,           32'hCAFEF00D);
        access(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1);
        check("nwa_ld_rd",   {31'd0, r_saw_rd}, 32'd1);
        check("nwa_ld_miss", bus.miss_count,    32'd2);
        check("nwa_ld_data", r_data,            32'hCAFEF00D);
        access(1'b0, 32'h20, 32'h0, 32'h0, 1);
        check("fill_hit",    {31'd0, r_saw_rd}, 32'd0);
        check("fill_data",   r_data,            32'hCAFEF00D);
        check("fill_hits",   bus.hit_count,     32'd3);

        // Same index 0, different tags: each evicts the other.
        access(1'b0, 32'h000, 32'h0, 32'h11111111, 1);
        check("cf0_data",    r_data,            32'h11111111);
        access(1'b0, 32'h100, 32'h0, 32'h22222222, 2);
        check("cf1_data",    r_data,            32'h22222222);
        check("cf1_stalls",  r_stalls,          32'd3);
        access(1'b0, 32'h000, 32'h0, 32'h11111111, 1);
        check("cf2_memrd",   {31'd0, r_saw_rd}, 32'd1);
        check("cf2_data",    r_data,            32'h11111111);
        check("cf_misses",   bus.miss_count,    32'd5);

        // Unaligned load bypasses and must not disturb line 4 (holding 0x10).
        access(1'b0, 32'h13, 32'h0, 32'hABCD0000, 1);
        check("ua_addr",     r_addr,            32'h13);
        check("ua_data",     r_data,            32'hABCD0000);
        access(1'b0, 32'h13, 32'h0, 32'hABCD0000, 1);
        check("ua_rpt_rd",   {31'd0, r_saw_rd}, 32'd1);
        check("ua_misses",   bus.miss_count,    32'd7);
        access(1'b0, 32'h10, 32'h0, 32'h0, 1);
        check("ua_line_rd",  {31'd0, r_saw_rd}, 32'd0);
        check("ua_line_dat", r_data,            32'h12345678);
        check("ua_hits",     bus.hit_count,     32'd4);
        check("never_both",  {31'd0, r_both},   32'd0);

        // Reset while a read is outstanding.
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h40;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("mid_memrd",   {31'd0, bus.mem_read}, 32'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn         = 1'b1;
        bus.cpu_read = 1'b0;
        check("mr_memrd",    {31'd0, bus.mem_read},  32'd0);
        check("mr_hits",     bus.hit_count,          32'd0);
        check("mr_misses",   bus.miss_count,         32'd0);
        check("mr_rddata",   bus.cpu_rddata,         32'd0);
        @(negedge clk);
        check("mr_stall",    {31'd0, bus.cpu_stall}, 32'd0);

        // Stray completion pulse in IDLE.
        bus.mem_ready  = 1'b1;
        bus.mem_rddata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        check("stray_memrd", {31'd0, bus.mem_read},  32'd0);
        check("stray_memwr", {31'd0, bus.mem_write}, 32'd0);
        check("stray_rddat", bus.cpu_rddata,         32'd0);
        @(negedge clk);
        check("stray_stall", {31'd0, bus.cpu_stall}, 32'd0);
        @(posedge clk);
        #1;

        access(1'b0, 32'h10, 32'h0, 32'h55555555, 1);
        check("pr_memrd",    {31'd0, r_saw_rd}, 32'd1);
        check("pr_stalls",   r_stalls,          32'd2);
        check("pr_data",     r_data,            32'h55555555);
        check("pr_misses",   bus.miss_count,    32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
